// File: rtl/sp_stream_module.sv
// Multi-target result scratchpad: addressed word writes, single-cycle target clear and
// a valid/ready stream-out engine. Optional lane-wise accumulate writes under SP_ACCUM_EN.
module sp_stream_module #(
  parameter  int SP_NTARGETS = 4,
  parameter  int DATA_WIDTH  = 32,
  parameter  int BUS_WIDTH   = 64,
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  localparam int DEPTH       = MAX_DIM * MAX_DIM,
  localparam int ADDR_W      = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH),
  localparam int TGT_W       = $clog2(SP_NTARGETS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 write_enable_i,
  input  logic [TGT_W-1:0]     write_target_i,
  input  logic [ADDR_W-1:0]    address_i,
  input  logic [BUS_WIDTH-1:0] data_i,
`ifdef SP_ACCUM_EN
  input  logic                 accum_i,
`endif
  input  logic                 clear_i,
  input  logic [TGT_W-1:0]     clear_target_i,
  input  logic                 rd_start_i,
  input  logic [TGT_W-1:0]     rd_target_i,
  input  logic [ADDR_W:0]      rd_len_i,
  input  logic                 rd_ready_i,
  output logic                 rd_valid_o,
  output logic [BUS_WIDTH-1:0] rd_data_o,
  output logic                 rd_last_o,
  output logic                 rd_busy_o,
  output logic                 rd_done_o,
  output logic                 rd_err_o
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  // Flop-based storage: a whole-target clear in one cycle rules out a RAM macro.
  logic [BUS_WIDTH-1:0] mem_reg [SP_NTARGETS][DEPTH];
  logic [BUS_WIDTH-1:0] wr_word;

  state_t               state_reg, state_next;
  logic [TGT_W-1:0]     tgt_reg, tgt_next;
  logic [ADDR_W:0]      len_reg, len_next;
  logic [ADDR_W-1:0]    ptr_reg, ptr_next;
  logic [BUS_WIDTH-1:0] data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 last_reg, last_next;
  logic                 done_reg, done_next;
  logic                 err_reg, err_next;
  logic [ADDR_W:0]      ptr_inc;
  logic                 len_ok;

`ifdef SP_ACCUM_EN
  logic [BUS_WIDTH-1:0] old_word;
  logic [BUS_WIDTH-1:0] sum_word;

  assign old_word = mem_reg[write_target_i][address_i];

  // Each lane wraps independently; no carry crosses a DATA_WIDTH boundary.
  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_lane
    assign sum_word[gi*DATA_WIDTH +: DATA_WIDTH] =
      old_word[gi*DATA_WIDTH +: DATA_WIDTH] + data_i[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign wr_word = accum_i ? sum_word : data_i;
`else
  assign wr_word = data_i;
`endif

  // Clear is tested first so it beats a write or accumulate to the same target.
  always_ff @(posedge clk_i) begin
    for (int t = 0; t < SP_NTARGETS; t++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (rst_i) begin
          mem_reg[t][a] <= '0;
        end else if (clear_i && clear_target_i == TGT_W'(t)) begin
          mem_reg[t][a] <= '0;
        end else if (write_enable_i && write_target_i == TGT_W'(t) &&
                     address_i == ADDR_W'(a)) begin
          mem_reg[t][a] <= wr_word;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    tgt_next   = tgt_reg;
    len_next   = len_reg;
    ptr_next   = ptr_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    ptr_inc    = {1'b0, ptr_reg} + LEN_ONE;
    len_ok     = (rd_len_i != '0) && (rd_len_i <= LEN_MAX);

    case (state_reg)
      ST_IDLE: begin
        if (rd_start_i) begin
          if (len_ok) begin
            tgt_next   = rd_target_i;
            len_next   = rd_len_i;
            ptr_next   = '0;
            data_next  = mem_reg[rd_target_i][0];
            valid_next = 1'b1;
            last_next  = (rd_len_i == LEN_ONE);
            state_next = ST_STREAM;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (valid_reg && rd_ready_i) begin
          if (last_reg) begin
            valid_next = 1'b0;
            last_next  = 1'b0;
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            // Prefetch the following word on the same edge that accepts this one.
            ptr_next  = ptr_inc[ADDR_W-1:0];
            data_next = mem_reg[tgt_reg][ptr_inc[ADDR_W-1:0]];
            last_next = (ptr_inc == len_reg - LEN_ONE);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      tgt_reg   <= '0;
      len_reg   <= '0;
      ptr_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      tgt_reg   <= tgt_next;
      len_reg   <= len_next;
      ptr_reg   <= ptr_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign rd_valid_o = valid_reg;
  assign rd_data_o  = data_reg;
  assign rd_last_o  = last_reg;
  assign rd_busy_o  = (state_reg == ST_STREAM);
  assign rd_done_o  = done_reg;
  assign rd_err_o   = err_reg;

endmodule

// File: tb/tb_sp_stream_module.sv
// Bench for sp_stream_module: directed sequences, a start-request table and a
// randomized run against a behavioural scratchpad/stream model.
module tb_sp_stream_module;

  localparam int TGT_W  = 2;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int BW     = 64;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              write_enable_i = 1'b0;
  logic [TGT_W-1:0]  write_target_i = '0;
  logic [ADDR_W-1:0] address_i = '0;
  logic [BW-1:0]     data_i = '0;
  logic              accum_i = 1'b0;
  logic              clear_i = 1'b0;
  logic [TGT_W-1:0]  clear_target_i = '0;
  logic              rd_start_i = 1'b0;
  logic [TGT_W-1:0]  rd_target_i = '0;
  logic [ADDR_W:0]   rd_len_i = '0;
  logic              rd_ready_i = 1'b0;
  logic              rd_valid_o, rd_last_o, rd_busy_o, rd_done_o, rd_err_o;
  logic [BW-1:0]     rd_data_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sp_stream_module dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .write_enable_i (write_enable_i),
    .write_target_i (write_target_i),
    .address_i      (address_i),
    .data_i         (data_i),
`ifdef SP_ACCUM_EN
    .accum_i        (accum_i),
`endif
    .clear_i        (clear_i),
    .clear_target_i (clear_target_i),
    .rd_start_i     (rd_start_i),
    .rd_target_i    (rd_target_i),
    .rd_len_i       (rd_len_i),
    .rd_ready_i     (rd_ready_i),
    .rd_valid_o     (rd_valid_o),
    .rd_data_o      (rd_data_o),
    .rd_last_o      (rd_last_o),
    .rd_busy_o      (rd_busy_o),
    .rd_done_o      (rd_done_o),
    .rd_err_o       (rd_err_o)
  );

  typedef struct {
    logic [ADDR_W:0] len;
    logic            exp_err;
    logic            exp_valid;
    logic            exp_last;
  } start_vec_t;

  // Behavioural model state
  logic [BW-1:0] m_mem [4][DEPTH];
  logic [BW-1:0] m_word;
  bit            m_active, m_done, m_err;
  int            m_tgt, m_len, m_k;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int tgt, input int addr, input logic [BW-1:0] d, input bit acc);
    write_enable_i = 1'b1;
    write_target_i = TGT_W'(tgt);
    address_i      = ADDR_W'(addr);
    data_i         = d;
    accum_i        = acc;
    step();
    write_enable_i = 1'b0;
    accum_i        = 1'b0;
  endtask

  task automatic start(input int tgt, input int len);
    rd_start_i  = 1'b1;
    rd_target_i = TGT_W'(tgt);
    rd_len_i    = (ADDR_W + 1)'(len);
    step();
    rd_start_i  = 1'b0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [BW-1:0] nw;
    m_done = 0;
    m_err  = 0;
    if (!m_active) begin
      if (rd_start_i) begin
        if (rd_len_i >= 1 && rd_len_i <= DEPTH) begin
          m_active = 1; m_tgt = int'(rd_target_i); m_len = int'(rd_len_i); m_k = 0;
          m_word = m_mem[m_tgt][0];
        end else m_err = 1;
      end
    end else if (rd_ready_i) begin
      if (m_k == m_len - 1) begin
        m_active = 0; m_done = 1;
      end else begin
        m_k++;
        m_word = m_mem[m_tgt][m_k];
      end
    end
    if (write_enable_i && !(clear_i && clear_target_i == write_target_i)) begin
      nw = data_i;
`ifdef SP_ACCUM_EN
      if (accum_i) begin
        nw[31:0]  = 32'(m_mem[write_target_i][address_i][31:0]  + data_i[31:0]);
        nw[63:32] = 32'(m_mem[write_target_i][address_i][63:32] + data_i[63:32]);
      end
`endif
      m_mem[write_target_i][address_i] = nw;
    end
    if (clear_i)
      for (int a = 0; a < DEPTH; a++) m_mem[clear_target_i][a] = '0;
  endtask

  initial begin
    start_vec_t vecs [5];
    int k, n;
    bit got_done;

    // Reset state
    rst_i = 1'b1;
    step(); step();
    chk("rst_valid", rd_valid_o, 0);
    chk("rst_data",  rd_data_o, 0);
    chk("rst_last",  rd_last_o, 0);
    chk("rst_busy",  rd_busy_o, 0);
    chk("rst_done",  rd_done_o, 0);
    chk("rst_err",   rd_err_o, 0);
    rst_i = 1'b0;

    // Stream an untouched target: four zero words
    rd_ready_i = 1'b1;
    start(0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", rd_valid_o, 1);
      chk("t1_data",  rd_data_o, 0);
      chk("t1_last",  rd_last_o, (i == 3));
      step();
    end
    chk("t1_done",  rd_done_o, 1);
    chk("t1_valid_end", rd_valid_o, 0);
    chk("t1_busy_end",  rd_busy_o, 0);
    step();
    chk("t1_done_pulse", rd_done_o, 0);

    // Written words, full throughput, len3
    for (int a = 0; a < 4; a++) write_word(2, a, BW'((a + 1) * 'h11), 0);
    start(2, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_valid", rd_valid_o, 1);
      chk("t2_data",  rd_data_o, BW'((i + 1) * 'h11));
      chk("t2_last",  rd_last_o, (i == 2));
      step();
    end
    chk("t2_done", rd_done_o, 1);
    chk("t2_valid_end", rd_valid_o, 0);
    step();

    // Same stream with ready stalls
    start(2, 3);
    k = 0; got_done = 0;
    for (int c = 0; c < 30 && !got_done; c++) begin
      rd_ready_i = (c % 3 == 0);
      chk("t3_valid", rd_valid_o, 1);
      chk("t3_data",  rd_data_o, BW'((k + 1) * 'h11));
      chk("t3_last",  rd_last_o, (k == 2));
      step();
      if (rd_ready_i) k++;
      if (k == 3) begin
        chk("t3_done", rd_done_o, 1);
        chk("t3_valid_end", rd_valid_o, 0);
        got_done = 1;
      end
    end
    chk("t3_words", k, 3);
    rd_ready_i = 1'b0;
    step();

    // Start-request table: illegal lengths error out, legal ones stream
    vecs[0] = '{len: 3'd0, exp_err: 1'b1, exp_valid: 1'b0, exp_last: 1'b0};
    vecs[1] = '{len: 3'd5, exp_err: 1'b1, exp_valid: 1'b0, exp_last: 1'b0};
    vecs[2] = '{len: 3'd7, exp_err: 1'b1, exp_valid: 1'b0, exp_last: 1'b0};
    vecs[3] = '{len: 3'd1, exp_err: 1'b0, exp_valid: 1'b1, exp_last: 1'b1};
    vecs[4] = '{len: 3'd2, exp_err: 1'b0, exp_valid: 1'b1, exp_last: 1'b0};
    for (int v = 0; v < 5; v++) begin
      start(3, int'(vecs[v].len));
      chk($sformatf("tab%0d_err", v),   rd_err_o,   vecs[v].exp_err);
      chk($sformatf("tab%0d_valid", v), rd_valid_o, vecs[v].exp_valid);
      chk($sformatf("tab%0d_busy", v),  rd_busy_o,  vecs[v].exp_valid);
      chk($sformatf("tab%0d_last", v),  rd_last_o,  vecs[v].exp_last);
      if (vecs[v].exp_valid) begin
        rd_ready_i = 1'b1;
        n = 0;
        while (!rd_done_o && n < 10) begin step(); n++; end
        chk($sformatf("tab%0d_drain", v), rd_done_o, 1);
        rd_ready_i = 1'b0;
      end
      step();
      chk($sformatf("tab%0d_err_pulse", v), rd_err_o, 0);
    end

    // Mid-stream write, clear+write, then reset
    for (int a = 0; a < 4; a++) write_word(1, a, BW'('h10 + a), 0);
    rd_ready_i = 1'b1;
    start(1, 4);
    step();
    rd_ready_i = 1'b0;
    chk("t5_word1", rd_data_o, 'h11);
    write_word(1, 3, 'hAB, 0);
    clear_i = 1'b1; clear_target_i = 2'd1;
    write_word(1, 2, 'hCD, 0);
    clear_i = 1'b0;
    chk("t5_hold", rd_data_o, 'h11);
    chk("t5_hold_valid", rd_valid_o, 1);
    rd_ready_i = 1'b1;
    step();
    chk("t5_word2", rd_data_o, 0);
    chk("t5_word2_last", rd_last_o, 0);
    rd_ready_i = 1'b0;
    step();
    rd_ready_i = 1'b1;
    step();
    chk("t5_word3", rd_data_o, 0);
    chk("t5_word3_last", rd_last_o, 1);
    rd_ready_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("t5_rst_valid", rd_valid_o, 0);
    chk("t5_rst_busy",  rd_busy_o, 0);
    chk("t5_rst_done",  rd_done_o, 0);
    chk("t5_rst_last",  rd_last_o, 0);
    start(2, 1);
    chk("t5_mem_zeroed", rd_data_o, 0);
    rd_ready_i = 1'b1;
    step();
    chk("t5_done", rd_done_o, 1);
    rd_ready_i = 1'b0;
    step();

`ifdef SP_ACCUM_EN
    // Lane-wise accumulate without cross-lane carry
    write_word(0, 0, {32'hFFFFFFFF, 32'h1}, 0);
    write_word(0, 0, {32'h1, 32'h2}, 1);
    start(0, 1);
    chk("t6_accum", rd_data_o, {32'h0, 32'h3});
    rd_ready_i = 1'b1;
    step();
    rd_ready_i = 1'b0;
    step();
`endif

    // Randomized run against the model
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    for (int t = 0; t < 4; t++)
      for (int a = 0; a < DEPTH; a++) m_mem[t][a] = '0;
    m_active = 0; m_done = 0; m_err = 0; m_word = '0;
    m_tgt = 0; m_len = 0; m_k = 0;
    for (int c = 0; c < 2000; c++) begin
      write_enable_i = 1'($urandom_range(0, 1));
      write_target_i = TGT_W'($urandom_range(0, 3));
      address_i      = ADDR_W'($urandom_range(0, 3));
      data_i         = {$urandom, $urandom};
      accum_i        = 1'($urandom_range(0, 1));
      clear_i        = ($urandom_range(0, 15) == 0);
      clear_target_i = TGT_W'($urandom_range(0, 3));
      rd_start_i     = ($urandom_range(0, 3) == 0);
      rd_target_i    = TGT_W'($urandom_range(0, 3));
      rd_len_i       = (ADDR_W + 1)'($urandom_range(0, 6));
      rd_ready_i     = ($urandom_range(0, 3) != 0);
      model_edge();
      step();
      chk("rnd_valid", rd_valid_o, m_active);
      chk("rnd_busy",  rd_busy_o,  m_active);
      chk("rnd_last",  rd_last_o,  m_active && (m_k == m_len - 1));
      chk("rnd_done",  rd_done_o,  m_done);
      chk("rnd_err",   rd_err_o,   m_err);
      if (m_active) chk("rnd_data", rd_data_o, m_word);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
